crc_unfold_stream: RTL
======================

CRC_UNFOLD_STREAM -- requirements
Module: crc_unfold_stream

Interface
REQ-001 Parameters SHALL be, one per line:
  CRC_W   5         remainder width, 2..32
  POLY    5'b00101  generator low bits, implicit x^CRC_W term (default x^5+x^2+1)
  J       3         unfold factor: message bits consumed per clock, 1..16
  INIT    0         remainder seed at start of each message
  AUGMENT 0         0 = direct (feedback) form; 1 = augmented form with CRC_W zero bits appended
REQ-002 Ports SHALL be, one per line:
  clk        input   1       single clock, all state on rising edge
  reset      input   1       synchronous, active-high
  in_valid   input   1       in_data beat offered
  in_ready   output  1       block can accept a beat
  in_data    input   J       message bits, bit J-1 is first in time (MSB-first)
  in_last    input   1       beat is final beat of message
  out_valid  output  1       crc_out holds a finished remainder
  out_ready  input   1       consumer accepts crc_out
  crc_out    output  CRC_W   remainder, bit CRC_W-1 = coefficient of x^(CRC_W-1)
REQ-003 The block SHALL have exactly one clock (clk); reset SHALL be synchronous and active-high.

Function
REQ-004 A beat SHALL transfer on a rising edge where in_valid && in_ready.
REQ-005 Every message SHALL be a whole number of J-bit beats; partial beats are not supported.
REQ-006 Per accepted beat, the remainder SHALL advance by J single-bit steps in one clock, equal to J serial LFSR steps applied MSB-first.
REQ-007 Direct step (AUGMENT=0): fb = r[CRC_W-1]^b; r = {r[CRC_W-2:0],0} ^ (fb ? POLY : 0).
REQ-008 Augmented step (AUGMENT=1): r = {r[CRC_W-2:0],b} ^ (r[CRC_W-1] ? POLY : 0).
REQ-009 FSM states SHALL be RUN, FLUSH, DONE; reset enters RUN with r = INIT.
REQ-010 RUN: in_ready=1; accepted beat with in_last=0 stays in RUN; with in_last=1 goes to DONE (AUGMENT=0) or FLUSH (AUGMENT=1).
REQ-011 FLUSH: in_ready=0; feeds zero bits, J per cycle, except the final cycle, which feeds only the remaining CRC_W mod J bits (when nonzero); exactly CRC_W zero bits total; lasts ceil(CRC_W/J) cycles; then DONE.
REQ-012 DONE: in_ready=0, out_valid=1, crc_out=r stable; on out_ready=1 go to RUN with r=INIT the same edge.
REQ-013 Latency: AUGMENT=0, out_valid rises the cycle after the last-beat edge; AUGMENT=1, ceil(CRC_W/J) cycles later than that.
REQ-014 out_valid SHALL not drop and crc_out SHALL not change until out_ready is sampled high.
REQ-015 in_valid with in_ready=0 SHALL be ignored and SHALL not alter r.
REQ-016 Single-beat message (in_last on first beat) SHALL be legal and follow REQ-010.
REQ-017 With INIT=0 both modes SHALL yield identical crc_out for the same message.

Reset
REQ-018 Reset SHALL dominate all other inputs on any edge, including mid-message, mid-FLUSH and in DONE.
REQ-019 Reset values: state=RUN, r=INIT, in_ready=1 from the first cycle after the reset edge; out_valid=0 and crc_out=INIT.
REQ-020 A partially accumulated message SHALL be discarded by reset with no output produced.

Structure
REQ-021 Package crc_pkg SHALL hold the FSM state typedef, default polynomial constants (CRC5_USB etc.) and the single-bit step function.
REQ-022 Sub-module crc_step_comb (combinational, parameters CRC_W, POLY, J, AUGMENT; inputs r, data, nbits; output r_next) SHALL implement the unfolded J-bit step, shared by RUN and FLUSH.

Verification
REQ-023 AUGMENT=0, defaults: beats 3'b101, 3'b011(last) -> out_valid the next cycle, crc_out=5'b10011.
REQ-024 AUGMENT=1, same beats -> crc_out=5'b10011, out_valid 2 cycles later than in REQ-023, in_ready=0 throughout FLUSH and DONE.
REQ-025 out_ready held low 5 cycles in DONE with in_valid=1 -> crc_out stable at 5'b10011, no beats accepted; out_ready=1 -> RUN, next message starts from INIT.
REQ-026 Reset asserted after first beat 3'b101 -> no output; following message 3'b101, 3'b011(last) -> 5'b10011.
REQ-027 Random messages of 1..40 beats, random in_valid/out_ready gaps, J in {1,3,8}, CRC_W in {5,16} -> crc_out matches bit-serial reference model for every message, in both modes.

Source files
------------

// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the unfolded CRC stream block:
//   - crc_state_e   : FSM state encoding (RUN, FLUSH, DONE)
//   - CRC*_ constants: common generator polynomials, low bits only
//                      (the x^CRC_W term is implicit)
//   - crc_bit_step  : one serial LFSR step, direct or augmented form,
//                     on a remainder held in the low w bits of a 32-bit word
// -----------------------------------------------------------------------------
package crc_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } crc_state_e;

   // Generator low bits; the leading x^CRC_W coefficient is implicit.
   localparam logic [4:0]  CRC5_USB  = 5'b00101;           // x^5+x^2+1
   localparam logic [15:0] CRC16_IBM = 16'h8005;           // x^16+x^15+x^2+1

   // One serial step on a remainder occupying bits [w-1:0] of r.
   //   direct    : fb = r[w-1]^b ; r = {r,0} ^ (fb ? poly : 0)
   //   augmented : fb = r[w-1]   ; r = {r,b} ^ (fb ? poly : 0)
   // Bits above w-1 of the result are always cleared.
   function automatic logic [31:0] crc_bit_step(
      input logic [31:0] r,
      input logic        b,
      input logic [31:0] poly,
      input int unsigned w,
      input logic        augment
   );
      logic [31:0] shifted;
      logic [31:0] mask;
      logic        fb;
      mask    = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      fb      = augment ? r[w-1] : (r[w-1] ^ b);
      shifted = {r[30:0], augment & b};
      return (shifted ^ (fb ? poly : 32'd0)) & mask;
   endfunction

endpackage

// File: rtl/crc_step_comb.sv
// -----------------------------------------------------------------------------
// crc_step_comb
// Purely combinational unfolded CRC step: applies up to J serial LFSR steps
// in one pass, consuming data bits MSB-first (data[J-1] is first in time).
// Only the first nbits of data are applied; the rest are skipped so the same
// logic can also run the short final flush cycle.
//
// Ports
//   r       in   CRC_W           current remainder
//   data    in   J               message (or zero-flush) bits, MSB first
//   nbits   in   clog2(J+1)      number of leading data bits to apply, 0..J
//   r_next  out  CRC_W           remainder after nbits steps
// -----------------------------------------------------------------------------
module crc_step_comb
   import crc_pkg::*;
#(
   parameter int unsigned      CRC_W   = 5,
   parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC5_USB),
   parameter int unsigned      J       = 3,
   parameter bit               AUGMENT = 1'b0
) (
   input  logic [CRC_W-1:0]       r,
   input  logic [J-1:0]           data,
   input  logic [$clog2(J+1)-1:0] nbits,
   output logic [CRC_W-1:0]       r_next
);

   logic [CRC_W-1:0] acc;

   always_comb begin
      acc = r;
      for (int i = 0; i < int'(J); i++) begin
         if (i < int'(nbits)) begin
            acc = CRC_W'(crc_bit_step(32'(acc), data[J-1-i], 32'(POLY),
                                      CRC_W, AUGMENT));
         end
      end
      r_next = acc;
   end

endmodule

// File: rtl/crc_unfold_stream.sv
// -----------------------------------------------------------------------------
// crc_unfold_stream
// Streaming CRC engine consuming J message bits per clock. Messages arrive
// as whole J-bit beats with a valid/ready handshake; the finished remainder
// is presented with a valid/ready handshake and held until taken.
// In augmented form, CRC_W zero bits are appended after the last beat
// (FLUSH state) before the result is presented.
//
// Ports
//   clk        in   1      single clock, rising edge
//   reset      in   1      synchronous, active-high, dominates all inputs
//   in_valid   in   1      in_data beat offered
//   in_ready   out  1      block can accept a beat (RUN state only)
//   in_data    in   J      message bits, bit J-1 first in time
//   in_last    in   1      beat is the final beat of the message
//   out_valid  out  1      crc_out holds a finished remainder
//   out_ready  in   1      consumer accepts crc_out
//   crc_out    out  CRC_W  remainder, bit CRC_W-1 = coefficient of x^(CRC_W-1)
// -----------------------------------------------------------------------------
module crc_unfold_stream
   import crc_pkg::*;
#(
   parameter int unsigned      CRC_W   = 5,
   parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC5_USB),
   parameter int unsigned      J       = 3,
   parameter logic [CRC_W-1:0] INIT    = '0,
   parameter bit               AUGMENT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [J-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CRC_W-1:0] crc_out
);

   // Flush timing: ceil(CRC_W/J) cycles, the last one carrying only the
   // leftover CRC_W mod J zero bits when that is nonzero.
   localparam int unsigned FLUSH_CYC = (CRC_W + J - 1) / J;
   localparam int unsigned TAIL_BITS = ((CRC_W % J) == 0) ? J : (CRC_W % J);
   localparam int unsigned NB_W      = $clog2(J + 1);
   localparam int unsigned CNT_W     = $clog2(FLUSH_CYC + 1);

   crc_state_e       state, state_nx;
   logic [CRC_W-1:0] r, r_nx, r_step;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [J-1:0]     step_data;
   logic [NB_W-1:0]  step_nbits;

   // Single unfolded step shared by RUN (message bits) and FLUSH (zeros).
   crc_step_comb #(
      .CRC_W   (CRC_W),
      .POLY    (POLY),
      .J       (J),
      .AUGMENT (AUGMENT)
   ) u_step (
      .r      (r),
      .data   (step_data),
      .nbits  (step_nbits),
      .r_next (r_step)
   );

   // NOTE: every register here is reset because a reset must both abandon a
   // half-built remainder and re-seed it; nothing is left to power-up value.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
         r     <= INIT;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking so all registers update from pre-edge values.
         state <= state_nx;
         r     <= r_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned (latch).
      state_nx   = state;
      r_nx       = r;
      cnt_nx     = cnt;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      step_data  = '0;
      step_nbits = NB_W'(J);

      unique case (state)
         ST_RUN: begin
            in_ready  = 1'b1;
            step_data = in_data;
            if (in_valid) begin
               r_nx = r_step;
               if (in_last) begin
                  if (AUGMENT) begin
                     state_nx = ST_FLUSH;
                     cnt_nx   = CNT_W'(FLUSH_CYC);
                  end else begin
                     state_nx = ST_DONE;
                  end
               end
            end
         end

         ST_FLUSH: begin
            // cnt counts flush cycles still to run, including this one.
            if (cnt == CNT_W'(1)) begin
               step_nbits = NB_W'(TAIL_BITS);
               state_nx   = ST_DONE;
            end
            r_nx   = r_step;
            cnt_nx = cnt - CNT_W'(1);
         end

         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = ST_RUN;
               r_nx     = INIT;
            end
         end

         default: begin
            state_nx = ST_RUN;
            r_nx     = INIT;
         end
      endcase
   end

   // The remainder register is the result; it is frozen while in DONE.
   assign crc_out = r;

endmodule
